// File: rtl/scan_transfer_receiver.sv
// Receiving end of the scanner transfer protocol: round-robin grant between two scanners and fixed-length frame capture.
// Define SCAN_RX_CHECKSUM_EN to expect a trailing XOR checksum word on every frame.
module scan_transfer_receiver #(
  parameter int DATA_WIDTH     = 8,
  parameter int FRAME_WORDS    = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_1,
  input  logic                  req_2,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic                  valid_1,
  input  logic [DATA_WIDTH-1:0] data_2,
  input  logic                  valid_2,
  output logic                  grant_1,
  output logic                  grant_2,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_done,
  output logic                  checksum_err,
  output logic                  timeout_err,
  output logic [3:0]            word_count,
  output logic [3:0]            frame_count,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECEIVE = 2'b01,
    DONE    = 2'b10,
    ABORT   = 2'b11
  } state_t;

  localparam logic [3:0] LAST_WORD     = 4'(FRAME_WORDS);
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t                cur_state;
  logic                  src_2;
  logic                  last_served_2;
  logic [7:0]            idle_cycles;
  logic                  sel_valid;
  logic                  sel_req;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;

`ifdef SCAN_RX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] running_xor;
`else
  assign checksum_err = 1'b0;
`endif

  // Only the granted source is looked at; the other scanner's lines are don't-care.
  assign sel_valid = src_2 ? valid_2 : valid_1;
  assign sel_req   = src_2 ? req_2   : req_1;
  assign sel_data  = src_2 ? data_2  : data_1;
  assign accept    = (cur_state == RECEIVE) && sel_valid;
  assign state     = cur_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state     <= IDLE;
      grant_1       <= 1'b0;
      grant_2       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
      word_count    <= 4'd0;
      frame_count   <= 4'd0;
      src_2         <= 1'b0;
      last_served_2 <= 1'b1;
      idle_cycles   <= 8'd0;
`ifdef SCAN_RX_CHECKSUM_EN
      checksum_err  <= 1'b0;
      running_xor   <= '0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
`ifdef SCAN_RX_CHECKSUM_EN
      checksum_err <= 1'b0;
`endif
      case (cur_state)
        IDLE: begin
          idle_cycles <= 8'd0;
          // On a tie, scanner 1 wins whenever scanner 2 was the one served last.
          if (req_1 && (!req_2 || last_served_2)) begin
            grant_1   <= 1'b1;
            src_2     <= 1'b0;
            cur_state <= RECEIVE;
          end else if (req_2) begin
            grant_2   <= 1'b1;
            src_2     <= 1'b1;
            cur_state <= RECEIVE;
          end
        end

        RECEIVE: begin
          if (accept) begin
            rx_data     <= sel_data;
            rx_valid    <= 1'b1;
            idle_cycles <= 8'd0;
`ifdef SCAN_RX_CHECKSUM_EN
            // Once all data words are in, the next accepted word is the checksum.
            if (word_count == LAST_WORD) begin
              grant_1    <= 1'b0;
              grant_2    <= 1'b0;
              frame_done <= 1'b1;
              cur_state  <= DONE;
              if (sel_data == running_xor) begin
                frame_count <= frame_count + 4'd1;
              end else begin
                checksum_err <= 1'b1;
              end
            end else begin
              word_count  <= word_count + 4'd1;
              running_xor <= running_xor ^ sel_data;
              if (!sel_req) begin
                grant_1   <= 1'b0;
                grant_2   <= 1'b0;
                cur_state <= ABORT;
              end
            end
`else
            word_count <= word_count + 4'd1;
            if (word_count + 4'd1 == LAST_WORD) begin
              grant_1     <= 1'b0;
              grant_2     <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 4'd1;
              cur_state   <= DONE;
            end else if (!sel_req) begin
              grant_1   <= 1'b0;
              grant_2   <= 1'b0;
              cur_state <= ABORT;
            end
`endif
          end else if (!sel_req) begin
            grant_1   <= 1'b0;
            grant_2   <= 1'b0;
            cur_state <= ABORT;
          end else if (idle_cycles + 8'd1 == TIMEOUT_LIMIT) begin
            grant_1     <= 1'b0;
            grant_2     <= 1'b0;
            timeout_err <= 1'b1;
            cur_state   <= ABORT;
          end else begin
            idle_cycles <= idle_cycles + 8'd1;
          end
        end

        DONE, ABORT: begin
          last_served_2 <= src_2;
          word_count    <= 4'd0;
          idle_cycles   <= 8'd0;
`ifdef SCAN_RX_CHECKSUM_EN
          running_xor   <= '0;
`endif
          cur_state     <= IDLE;
        end

        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_transfer_receiver.sv
// Directed bench for scan_transfer_receiver: a vector table for the basic frame plus hand-written corner sequences.
module tb_scan_transfer_receiver;

  localparam int FW = 10;
  localparam int TO = 255;
`ifdef SCAN_RX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct packed {
    logic       r1;
    logic       r2;
    logic       v1;
    logic [7:0] d1;
    logic       v2;
    logic [7:0] d2;
  } in_t;

  typedef struct packed {
    logic       g1;
    logic       g2;
    logic       rxv;
    logic [7:0] rxd;
    logic       fd;
    logic       ce;
    logic       te;
    logic [3:0] wc;
    logic [3:0] fc;
    logic [1:0] st;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_1 = 1'b0, req_2 = 1'b0, valid_1 = 1'b0, valid_2 = 1'b0;
  logic [7:0] data_1 = 8'd0, data_2 = 8'd0;
  logic       grant_1, grant_2, rx_valid, frame_done, checksum_err, timeout_err;
  logic [7:0] rx_data;
  logic [3:0] word_count, frame_count;
  logic [1:0] state;

  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  scan_transfer_receiver #(.DATA_WIDTH(8), .FRAME_WORDS(FW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_1(req_1), .req_2(req_2),
    .data_1(data_1), .valid_1(valid_1),
    .data_2(data_2), .valid_2(valid_2),
    .grant_1(grant_1), .grant_2(grant_2),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_done(frame_done), .checksum_err(checksum_err), .timeout_err(timeout_err),
    .word_count(word_count), .frame_count(frame_count), .state(state)
  );

  function automatic in_t mk_in(bit r1, bit r2, bit v1, logic [7:0] d1, bit v2, logic [7:0] d2);
    in_t s;
    s.r1 = r1; s.r2 = r2; s.v1 = v1; s.d1 = d1; s.v2 = v2; s.d2 = d2;
    return s;
  endfunction

  // A word from the chosen source, with noise on the other source's lines.
  function automatic in_t word_in(bit s2, logic [7:0] d, bit r1, bit r2);
    if (s2) return mk_in(r1, r2, 1'b1, 8'hEE, 1'b1, d);
    return mk_in(r1, r2, 1'b1, d, 1'b1, 8'hEE);
  endfunction

  function automatic out_t mk_out(bit g1, bit g2, bit rxv, logic [7:0] rxd, bit fd, bit ce, bit te,
                                  logic [3:0] wc, logic [3:0] fc, logic [1:0] st);
    out_t o;
    o.g1 = g1; o.g2 = g2; o.rxv = rxv; o.rxd = rxd; o.fd = fd; o.ce = ce; o.te = te;
    o.wc = wc; o.fc = fc; o.st = st;
    return o;
  endfunction

  function automatic out_t sample_outputs();
    out_t o;
    o = {grant_1, grant_2, rx_valid, rx_data, frame_done, checksum_err, timeout_err,
         word_count, frame_count, state};
    return o;
  endfunction

  task automatic apply_stimulus(input in_t s);
    @(negedge clk);
    req_1 = s.r1; req_2 = s.r2; valid_1 = s.v1; data_1 = s.d1; valid_2 = s.v2; data_2 = s.d2;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input out_t exp);
    out_t act;
    act = sample_outputs();
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got g1=%b g2=%b rxv=%b rxd=%h fd=%b ce=%b te=%b wc=%0d fc=%0d st=%0d, want g1=%b g2=%b rxv=%b rxd=%h fd=%b ce=%b te=%b wc=%0d fc=%0d st=%0d",
               name, act.g1, act.g2, act.rxv, act.rxd, act.fd, act.ce, act.te, act.wc, act.fc, act.st,
               exp.g1, exp.g2, exp.rxv, exp.rxd, exp.fd, exp.ce, exp.te, exp.wc, exp.fc, exp.st);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_1 = 1'b0; req_2 = 1'b0; valid_1 = 1'b0; valid_2 = 1'b0; data_1 = 8'd0; data_2 = 8'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sends every data word of a frame (plus the checksum word when enabled); ends in DONE.
  task automatic send_full_frame(input bit s2, input bit r1, input bit r2);
    for (int i = 1; i <= FW; i++) apply_stimulus(word_in(s2, 8'(i), r1, r2));
    if (CK) apply_stimulus(word_in(s2, 8'h0B, r1, r2));
  endtask

  initial begin
    in_t        idle_in;
    logic [7:0] last_rx;
    idle_in = mk_in(0, 0, 0, 8'h00, 0, 8'h00);
    last_rx = CK ? 8'h0B : 8'h0A;

    vecs.push_back('{idle_in, mk_out(0, 0, 0, 8'h00, 0, 0, 0, 4'd0, 4'd0, 2'd0)});
    vecs.push_back('{mk_in(1, 0, 0, 8'h00, 1, 8'hEE), mk_out(1, 0, 0, 8'h00, 0, 0, 0, 4'd0, 4'd0, 2'd1)});
    for (int i = 1; i <= FW; i++) begin
      if (i == FW && !CK)
        vecs.push_back('{word_in(0, 8'(i), 1, 0), mk_out(0, 0, 1, 8'(i), 1, 0, 0, 4'(i), 4'd1, 2'd2)});
      else
        vecs.push_back('{word_in(0, 8'(i), 1, 0), mk_out(1, 0, 1, 8'(i), 0, 0, 0, 4'(i), 4'd0, 2'd1)});
    end
    if (CK)
      vecs.push_back('{word_in(0, 8'h0B, 1, 0), mk_out(0, 0, 1, 8'h0B, 1, 0, 0, 4'd10, 4'd1, 2'd2)});
    vecs.push_back('{idle_in, mk_out(0, 0, 0, last_rx, 0, 0, 0, 4'd0, 4'd1, 2'd0)});
    vecs.push_back('{idle_in, mk_out(0, 0, 0, last_rx, 0, 0, 0, 4'd0, 4'd1, 2'd0)});

    do_reset();
    check_output("reset", mk_out(0, 0, 0, 8'h00, 0, 0, 0, 4'd0, 4'd0, 2'd0));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].stim);
      check_output($sformatf("frame_vec%0d", i), vecs[i].exp);
    end

    // Tie after reset: scanner 1 first, then scanner 2 after one IDLE cycle.
    do_reset();
    apply_stimulus(mk_in(1, 1, 0, 8'h00, 0, 8'h00));
    check_output("tie_first_grant", mk_out(1, 0, 0, 8'h00, 0, 0, 0, 4'd0, 4'd0, 2'd1));
    send_full_frame(0, 1, 1);
    check_output("tie_done", mk_out(0, 0, 1, last_rx, 1, 0, 0, 4'd10, 4'd1, 2'd2));
    apply_stimulus(mk_in(1, 1, 0, 8'h00, 0, 8'h00));
    check_output("tie_idle_gap", mk_out(0, 0, 0, last_rx, 0, 0, 0, 4'd0, 4'd1, 2'd0));
    apply_stimulus(mk_in(1, 1, 0, 8'h00, 0, 8'h00));
    check_output("tie_second_grant", mk_out(0, 1, 0, last_rx, 0, 0, 0, 4'd0, 4'd1, 2'd1));
    apply_stimulus(idle_in);
    check_output("tie_drop_abort", mk_out(0, 0, 0, last_rx, 0, 0, 0, 4'd0, 4'd1, 2'd3));

    // Valid gaps with the non-granted scanner toggling.
    do_reset();
    apply_stimulus(mk_in(1, 0, 0, 8'h00, 0, 8'h00));
    for (int w = 1; w <= FW; w++) begin
      apply_stimulus(mk_in(1, 0, 1, 8'(w), w[0], 8'hFF));
      if (w == 3 || w == 7) begin
        check_val($sformatf("gap_wc%0d", w), int'(word_count), w);
        check_val($sformatf("gap_rxd%0d", w), int'(rx_data), w);
      end
      if (w < FW || CK)
        for (int g = 0; g < 3; g++) apply_stimulus(mk_in(1, 0, 0, 8'h00, g[0] ^ 1'b1, 8'hF0 + 8'(g)));
    end
    if (CK) apply_stimulus(mk_in(1, 0, 1, 8'h0B, 1, 8'hFF));
    check_output("gap_done", mk_out(0, 0, 1, last_rx, 1, 0, 0, 4'd10, 4'd1, 2'd2));

    // Timeout: four words from scanner 2, then silence.
    do_reset();
    apply_stimulus(mk_in(0, 1, 0, 8'h00, 0, 8'h00));
    for (int i = 1; i <= 4; i++) apply_stimulus(word_in(1, 8'(i), 0, 1));
    for (int k = 1; k < TO; k++) apply_stimulus(mk_in(0, 1, 1, 8'hEE, 0, 8'h00));
    check_output("timeout_edge_minus1", mk_out(0, 1, 0, 8'h04, 0, 0, 0, 4'd4, 4'd0, 2'd1));
    apply_stimulus(mk_in(0, 1, 0, 8'h00, 0, 8'h00));
    check_output("timeout_abort", mk_out(0, 0, 0, 8'h04, 0, 0, 1, 4'd4, 4'd0, 2'd3));
    apply_stimulus(idle_in);
    check_output("timeout_idle", mk_out(0, 0, 0, 8'h04, 0, 0, 1, 4'd0, 4'd0, 2'd0));
    for (int k = 0; k < 5; k++) apply_stimulus(idle_in);
    check_val("timeout_sticky", int'(timeout_err), 1);

    // Accept on the would-be timeout edge keeps the frame alive.
    do_reset();
    apply_stimulus(mk_in(1, 0, 0, 8'h00, 0, 8'h00));
    apply_stimulus(word_in(0, 8'h31, 1, 0));
    for (int k = 1; k < TO; k++) apply_stimulus(mk_in(1, 0, 0, 8'h00, 0, 8'h00));
    apply_stimulus(word_in(0, 8'h32, 1, 0));
    check_output("timeout_accept_wins", mk_out(1, 0, 1, 8'h32, 0, 0, 0, 4'd2, 4'd0, 2'd1));

    // Request dropped after five words.
    do_reset();
    apply_stimulus(mk_in(1, 0, 0, 8'h00, 0, 8'h00));
    for (int i = 1; i <= 5; i++) apply_stimulus(word_in(0, 8'(i), 1, 0));
    apply_stimulus(idle_in);
    check_output("drop_abort", mk_out(0, 0, 0, 8'h05, 0, 0, 0, 4'd5, 4'd0, 2'd3));
    apply_stimulus(idle_in);
    check_output("drop_idle", mk_out(0, 0, 0, 8'h05, 0, 0, 0, 4'd0, 4'd0, 2'd0));

    // Final word arriving with the request dropping: DONE wins.
    apply_stimulus(mk_in(1, 0, 0, 8'h00, 0, 8'h00));
    for (int i = 1; i < FW; i++) apply_stimulus(word_in(0, 8'(i), 1, 0));
    if (CK) begin
      apply_stimulus(word_in(0, 8'(FW), 1, 0));
      apply_stimulus(word_in(0, 8'h0B, 0, 0));
    end else begin
      apply_stimulus(word_in(0, 8'(FW), 0, 0));
    end
    check_output("final_word_drop", mk_out(0, 0, 1, last_rx, 1, 0, 0, 4'd10, 4'd1, 2'd2));

    // Asynchronous reset in the middle of a frame.
    apply_stimulus(idle_in);
    apply_stimulus(mk_in(0, 1, 0, 8'h00, 0, 8'h00));
    for (int i = 1; i <= 3; i++) apply_stimulus(word_in(1, 8'h40 + 8'(i), 0, 1));
    #2 reset = 1'b1;
    #1 check_output("reset_mid_frame", mk_out(0, 0, 0, 8'h00, 0, 0, 0, 4'd0, 4'd0, 2'd0));
    @(negedge clk);
    reset = 1'b0;
    req_1 = 1'b0; req_2 = 1'b0; valid_1 = 1'b0; valid_2 = 1'b0;

`ifdef SCAN_RX_CHECKSUM_EN
    // Bad checksum: frame_done still pulses, frame_count holds.
    do_reset();
    apply_stimulus(mk_in(1, 0, 0, 8'h00, 0, 8'h00));
    for (int i = 1; i <= FW; i++) apply_stimulus(word_in(0, 8'(i), 1, 0));
    apply_stimulus(word_in(0, 8'h00, 1, 0));
    check_output("checksum_bad", mk_out(0, 0, 1, 8'h00, 1, 1, 0, 4'd10, 4'd0, 2'd2));
    apply_stimulus(idle_in);
    check_output("checksum_err_pulse", mk_out(0, 0, 0, 8'h00, 0, 0, 0, 4'd0, 4'd0, 2'd0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/scan_transfer_receiver.md
Name: scan_transfer_receiver

Overview:
- Receiving end of the scanner transfer protocol.
- Arbitrates between the two scanners' ready-to-transfer requests and grants one source at a time.
- Accepts a fixed-length frame of data words from the granted scanner and reports frame and word counts for the HEX display logic.
- Sits beside the two scanner instances in the top-level scanner system.

Parameters:
- DATA_WIDTH, 8, width of one transferred word.
- FRAME_WORDS, 10, data words per frame; legal range 1..15.
- TIMEOUT_CYCLES, 255, idle cycles without an accepted word before the frame is aborted; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_1  in  1  scanner 1 ready-to-transfer
- req_2  in  1  scanner 2 ready-to-transfer
- data_1  in  DATA_WIDTH  scanner 1 word
- valid_1  in  1  data_1 valid
- data_2  in  DATA_WIDTH  scanner 2 word
- valid_2  in  1  data_2 valid
- grant_1  out  1  scanner 1 may send
- grant_2  out  1  scanner 2 may send
- rx_data  out  DATA_WIDTH  last accepted word
- rx_valid  out  1  one-cycle pulse per accepted word
- frame_done  out  1  one-cycle pulse at end of frame
- checksum_err  out  1  one-cycle pulse, checksum mismatch
- timeout_err  out  1  sticky timeout flag
- word_count  out  4  words accepted in current frame
- frame_count  out  4  completed good frames, mod 16
- state  out  2  current state, for display

Behaviour:
- Reset (async, immediate): state=IDLE, all outputs 0, last_served=2 so scanner 1 wins the first tie, timeout counter 0.
- States: IDLE=00, RECEIVE=01, DONE=10, ABORT=11. All outputs are registered.
- IDLE:
  - If exactly one req is high, register that source's grant and go to RECEIVE on the next edge.
  - If both are high, grant the source that is not last_served (round-robin).
  - If neither is high, stay in IDLE.
- RECEIVE, word acceptance:
  - A word is accepted on any edge where the granted source's valid=1.
  - On acceptance: rx_data<=word, rx_valid=1 for one cycle, word_count+1, timeout counter cleared.
  - The non-granted source's valid and data are ignored.
- RECEIVE, frame end: when word_count reaches FRAME_WORDS (on the accepting edge), go to DONE.
- RECEIVE, timeout: the timeout counter increments every cycle without an accepted word. On reaching TIMEOUT_CYCLES, set timeout_err=1 (sticky until reset) and go to ABORT.
- RECEIVE, request dropped: if the granted req drops before the frame completes, go to ABORT on the next edge. timeout_err is not set.
- DONE (one cycle):
  - grant deasserted, frame_done=1, frame_count+1 with wrap 15->0.
  - last_served=current source, word_count cleared, then IDLE.
- ABORT (one cycle):
  - grant deasserted, frame_count unchanged, last_served=current source.
  - word_count cleared, then IDLE. Any partial frame is discarded.
- Grant timing:
  - A grant is never held in IDLE.
  - grant_1 and grant_2 are never high together.
  - After any frame ends, a minimum of one IDLE cycle precedes the next grant.
- Same-edge events:
  - Timeout and an accepted word on the same edge: the accept wins.
  - Final word and a req drop on the same edge: DONE wins.
- Reset mid-frame: immediate return to the reset values above; the partial frame is lost.

Optional Feature:
- Macro: SCAN_RX_CHECKSUM_EN.
- With the macro:
  - Each frame is FRAME_WORDS data words followed by one checksum word, equal to the XOR of the data words.
  - A running XOR is kept over the data words; the checksum word is accepted normally (rx_valid pulses) but does not increment word_count.
  - On a mismatch, DONE still pulses frame_done, checksum_err=1 on the same cycle, and frame_count is not incremented.
  - The running XOR clears in DONE, ABORT and reset.
- Without the macro: no checksum word is expected, and checksum_err is tied to 0.

Test Plan:
- Single frame: req_1=1, 10 words 0x01..0x0A on consecutive cycles.
  -> grant_1 high 1 cycle after req, 10 rx_valid pulses, rx_data=0x0A, frame_done pulse, frame_count=1, grant_1 low.
- Tie after reset: req_1 and req_2 high together.
  -> scanner 1 granted first; after its frame completes, scanner 2 is granted after exactly one IDLE cycle.
- Valid gaps and wrong source: granted scanner 1 sends words with 3-cycle gaps while valid_2 toggles.
  -> only scanner 1 words accepted, word_count=10 at DONE, no timeout.
- Timeout: grant scanner 2, send 4 words, then stop.
  -> ABORT after 255 idle cycles, timeout_err=1 and stays 1, frame_count unchanged, word_count=0.
- Request drop and reset: drop req_1 after 5 words -> ABORT, timeout_err stays 0. Separately, assert reset mid-frame -> all outputs 0 immediately.
- With SCAN_RX_CHECKSUM_EN:
  - Words 0x01..0x0A with checksum 0x0B -> frame_done, checksum_err=0, frame_count+1.
  - Same frame with checksum 0x00 -> checksum_err pulse, frame_count unchanged.
